// File: rtl/voice_scheduler.sv
// voice_scheduler
// Polyphonic voice allocator and square-wave tone generator. Key press/release
// events arrive over a valid/ready handshake. Each accepted event spends one
// LOOKUP cycle, during which the shared note/octave divider table is addressed.
// At the end of that cycle the chosen voice is loaded, retriggered or cleared.
// Every active voice runs a half-period counter that toggles its wave output.
//
// Ports:
//   clk, n_rst                      clock, async active-low reset
//   key_valid/key_ready             event handshake (ready only in IDLE)
//   key_on, key_note, key_octave    event payload (press/release, note 0..12, octave)
//   lut_note, lut_octave            registered address into the divider table
//   lut_divider                     combinational divider returned by the table
//   voice_active, voice_wave        per-voice sounding flag and square wave
//
// state  | meaning
// IDLE   | ready for a key event
// LOOKUP | table addressed with captured event; voice update on exiting edge

module voice_scheduler #(
  parameter int VOICES = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              key_on,
  input  logic [3:0]        key_note,
  input  logic [2:0]        key_octave,
  output logic [3:0]        lut_note,
  output logic [2:0]        lut_octave,
  input  logic [18:0]       lut_divider,
  output logic [VOICES-1:0] voice_active,
  output logic [VOICES-1:0] voice_wave
);

  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOOKUP = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic              cap_on;
  logic [3:0]        v_note [VOICES];
  logic [2:0]        v_oct  [VOICES];
  logic [18:0]       v_div  [VOICES];
  logic [18:0]       v_cnt  [VOICES];
  logic [VOICES-1:0] act_q;
  logic [VOICES-1:0] wave_q;
  logic [IW-1:0]     steal_ptr;

  logic [VOICES-1:0] match;
  logic              hit, has_free, upd, do_steal;
  logic [IW-1:0]     hit_idx, free_idx, sel_idx;
  logic [18:0]       div_load;

  assign key_ready    = (state == IDLE);
  assign voice_active = act_q;
  assign voice_wave   = wave_q;
  assign div_load     = (lut_divider == 19'd0) ? 19'd1 : lut_divider;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      cap_on     <= 1'b0;
      lut_note   <= 4'd0;
      lut_octave <= 3'd0;
    end else begin
      state <= state_nxt;
      if (key_valid && key_ready) begin
        cap_on     <= key_on;
        lut_note   <= key_note;
        lut_octave <= key_octave;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    match     = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    has_free  = 1'b0;
    free_idx  = '0;
    case (state)
      IDLE:    if (key_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    for (int i = 0; i < VOICES; i++) begin
      match[i] = act_q[i] && (v_note[i] == lut_note) && (v_oct[i] == lut_octave);
    end
    // Descending scan so the lowest index wins.
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!act_q[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    sel_idx  = hit ? hit_idx : (has_free ? free_idx : steal_ptr);
    do_steal = cap_on && !hit && !has_free;
    // Releases only act on a match; illegal notes never act.
    upd      = (state == LOOKUP) && (lut_note <= 4'd12) && (cap_on || hit);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      steal_ptr <= '0;
    end else if (upd && do_steal) begin
      steal_ptr <= (steal_ptr == IW'(VOICES - 1)) ? '0 : steal_ptr + IW'(1);
    end
  end

  // The LOOKUP update has priority over the voice's own counter wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_q  <= '0;
      wave_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        v_note[i] <= 4'd0;
        v_oct[i]  <= 3'd0;
        v_div[i]  <= 19'd0;
        v_cnt[i]  <= 19'd0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (upd && (sel_idx == IW'(i))) begin
          v_cnt[i]  <= 19'd0;
          wave_q[i] <= 1'b0;
          act_q[i]  <= cap_on;
          if (cap_on) begin
            v_div[i]  <= div_load;
            v_note[i] <= lut_note;
            v_oct[i]  <= lut_octave;
          end
        end else if (act_q[i]) begin
          if (v_cnt[i] == v_div[i] - 19'd1) begin
            v_cnt[i]  <= 19'd0;
            wave_q[i] <= ~wave_q[i];
          end else begin
            v_cnt[i] <= v_cnt[i] + 19'd1;
          end
        end else begin
          v_cnt[i]  <= 19'd0;
          wave_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  localparam int V = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          key_valid = 1'b0;
  logic          key_ready;
  logic          key_on = 1'b0;
  logic [3:0]    key_note = 4'd0;
  logic [2:0]    key_octave = 3'd0;
  logic [3:0]    lut_note;
  logic [2:0]    lut_octave;
  logic [18:0]   lut_divider;
  logic [V-1:0]  voice_active;
  logic [V-1:0]  voice_wave;

  int errors = 0;
  int checks = 0;

  // Divider table model: 0 = pitch table, 1 = constant, 2 = small hash (may be 0)
  int lut_mode = 0;
  int lut_const = 5;

  // Behavioural reference state
  int cyc = 0;
  int m_act [V];
  int m_note [V];
  int m_oct [V];
  int m_div [V];
  int m_start [V];
  int m_sp = 0;
  int m_pend = 0;
  int m_on = 0;
  int m_cnote = 0;
  int m_coct = 0;

  voice_scheduler #(.VOICES(V)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_on       (key_on),
    .key_note     (key_note),
    .key_octave   (key_octave),
    .lut_note     (lut_note),
    .lut_octave   (lut_octave),
    .lut_divider  (lut_divider),
    .voice_active (voice_active),
    .voice_wave   (voice_wave)
  );

  always #5 clk = ~clk;

  function automatic int lut_val(int note, int oct, int mode, int cval);
    int base;
    if (mode == 1) return cval;
    if (mode == 2) return (note * 5 + oct * 3) % 6;
    if (note == 12) base = 152890;
    else if (note < 12) base = 300000 - note * 12000;
    else base = 524287;
    return base >> oct;
  endfunction

  always @(lut_note or lut_octave or lut_mode or lut_const)
    lut_divider = 19'(lut_val(int'(lut_note), int'(lut_octave), lut_mode, lut_const));

  function automatic logic [V-1:0] exp_active();
    logic [V-1:0] a;
    for (int i = 0; i < V; i++) a[i] = (m_act[i] != 0);
    return a;
  endfunction

  // Square wave of period 2*div, low for the first div cycles after load.
  function automatic logic [V-1:0] exp_wave();
    logic [V-1:0] w;
    for (int i = 0; i < V; i++)
      w[i] = (m_act[i] != 0) && ((((cyc - m_start[i]) / m_div[i]) % 2) == 1);
    return w;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < V; i++) begin
        m_act[i] = 0; m_note[i] = 0; m_oct[i] = 0; m_div[i] = 1; m_start[i] = 0;
      end
      m_sp = 0; m_pend = 0; m_on = 0; m_cnote = 0; m_coct = 0;
    end else begin
      cyc++;
      if (m_pend != 0) begin
        int idx;
        int d;
        m_pend = 0;
        if (m_cnote <= 12) begin
          idx = -1;
          for (int i = 0; i < V; i++)
            if (idx < 0 && m_act[i] != 0 && m_note[i] == m_cnote && m_oct[i] == m_coct) idx = i;
          if (m_on != 0) begin
            for (int i = 0; i < V; i++)
              if (idx < 0 && m_act[i] == 0) idx = i;
            if (idx < 0) begin
              idx = m_sp;
              m_sp = (m_sp + 1) % V;
            end
            d = lut_val(m_cnote, m_coct, lut_mode, lut_const);
            if (d == 0) d = 1;
            m_act[idx] = 1; m_note[idx] = m_cnote; m_oct[idx] = m_coct;
            m_div[idx] = d; m_start[idx] = cyc;
          end else if (idx >= 0) begin
            m_act[idx] = 0;
          end
        end
      end else if (key_valid) begin
        m_pend = 1;
        m_on = int'(key_on);
        m_cnote = int'(key_note);
        m_coct = int'(key_octave);
      end
    end
  end

  // Stimulus only: issue one event, return at the negedge of the LOOKUP cycle.
  task automatic send(input logic on, input int note, input int oct);
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: key_ready=%b required 1", key_ready);
    end
    key_on = on; key_note = 4'(note); key_octave = 3'(oct); key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    key_valid = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      key_valid = 1'(($urandom) & 1); key_on = 1'(($urandom) & 1);
      key_note = 4'($urandom); key_octave = 3'($urandom);
      #1;
      checks++;
      if (key_ready !== 1'b1 || voice_active !== '0 || voice_wave !== '0 ||
          lut_note !== 4'd0 || lut_octave !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold: ready=%b active=%b wave=%b note=%0d oct=%0d required 1/0/0/0/0",
                 key_ready, voice_active, voice_wave, lut_note, lut_octave);
      end
    end
    @(negedge clk);
    key_valid = 1'b0;
    n_rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (key_ready !== 1'b1 || voice_active !== '0 || voice_wave !== '0 ||
          lut_note !== 4'd0 || lut_octave !== 3'd0) begin
        errors++;
        $display("FAIL reset_after: ready=%b active=%b wave=%b note=%0d oct=%0d required 1/0/0/0/0",
                 key_ready, voice_active, voice_wave, lut_note, lut_octave);
      end
    end
  endtask

  task automatic test_single_press();
    lut_mode = 1; lut_const = 5;
    send(1'b1, 9, 3);
    checks++;
    if (lut_note !== 4'd9 || lut_octave !== 3'd3 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_lut: note=%0d oct=%0d ready=%b required 9/3/0", lut_note, lut_octave, key_ready);
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (voice_active[0] !== 1'b1 || voice_wave[0] !== 1'(((k / 5) % 2)) ||
          voice_wave !== exp_wave() || key_ready !== 1'b1) begin
        errors++;
        $display("FAIL single_wave k=%0d: active=%b wave=%b ready=%b required act0=1 wave0=%0d wave=%b",
                 k, voice_active, voice_wave, key_ready, (k / 5) % 2, exp_wave());
      end
    end
    send(1'b0, 9, 3);
    @(negedge clk);
    checks++;
    if (voice_active !== '0 || voice_wave !== '0) begin
      errors++;
      $display("FAIL single_release: active=%b wave=%b required 0/0", voice_active, voice_wave);
    end
  endtask

  task automatic test_alloc_steal();
    int t_on [13]   = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0};
    int t_note [13] = '{0, 1, 2, 3, 4, 5, 2, 6, 6, 8, 9, 8, 9};
    logic [V-1:0] t_act [13] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
                                 4'b1011, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1011};
    do_reset();
    lut_mode = 1; lut_const = 3;
    for (int s = 0; s < 13; s++) begin
      send(1'(t_on[s]), t_note[s], 0);
      repeat (4) begin
        @(negedge clk);
        checks++;
        if (voice_active !== t_act[s] || voice_active !== exp_active() || voice_wave !== exp_wave()) begin
          errors++;
          $display("FAIL alloc step=%0d: active=%b wave=%b required active=%b wave=%b",
                   s, voice_active, voice_wave, t_act[s], exp_wave());
        end
      end
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    lut_mode = 1; lut_const = 4;
    send(1'b1, 7, 2);
    repeat (6) @(negedge clk);
    checks++;
    if (voice_wave[0] !== 1'b1) begin
      errors++;
      $display("FAIL retrig_high: wave0=%b required 1", voice_wave[0]);
    end
    send(1'b1, 7, 2);
    @(negedge clk);
    checks++;
    if (voice_active !== 4'b0001 || voice_wave !== 4'b0000) begin
      errors++;
      $display("FAIL retrig_restart: active=%b wave=%b required 0001/0000", voice_active, voice_wave);
    end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (voice_active !== exp_active() || voice_wave !== exp_wave()) begin
        errors++;
        $display("FAIL retrig_run: active=%b wave=%b required %b/%b",
                 voice_active, voice_wave, exp_active(), exp_wave());
      end
    end
    send(1'b0, 8, 2);
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (voice_active !== 4'b0001 || voice_wave !== exp_wave()) begin
        errors++;
        $display("FAIL unknown_release: active=%b wave=%b required 0001/%b",
                 voice_active, voice_wave, exp_wave());
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    lut_mode = 0;
    send(1'b1, 13, 0);
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL illegal_busy: ready=%b required 0", key_ready);
    end
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || voice_active !== '0) begin
      errors++;
      $display("FAIL illegal_drop: ready=%b active=%b required 1/0000", key_ready, voice_active);
    end
    send(1'b1, 12, 7);
    for (int k = 0; k < 2 * 1194 + 6; k++) begin
      @(negedge clk);
      checks++;
      if (voice_active !== 4'b0001 || voice_wave[0] !== 1'(((k / 1194) % 2)) || voice_wave !== exp_wave()) begin
        errors++;
        if (errors < 20)
          $display("FAIL high_note k=%0d: active=%b wave=%b required 0001 wave0=%0d",
                   k, voice_active, voice_wave, (k / 1194) % 2);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    lut_mode = 2;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      checks++;
      if (key_ready !== (m_pend == 0) || lut_note !== 4'(m_cnote) || lut_octave !== 3'(m_coct) ||
          voice_active !== exp_active() || voice_wave !== exp_wave()) begin
        errors++;
        if (errors < 20)
          $display("FAIL random k=%0d: ready=%b note=%0d oct=%0d active=%b wave=%b required %0d/%0d/%0d/%b/%b",
                   k, key_ready, lut_note, lut_octave, voice_active, voice_wave,
                   (m_pend == 0), m_cnote, m_coct, exp_active(), exp_wave());
      end
      r = int'($urandom_range(15, 0));
      key_valid = 1'($urandom_range(1, 0));
      key_on = ($urandom_range(2, 0) != 0);
      key_note = (r < 12) ? 4'(r % 5) : 4'(r);
      key_octave = 3'($urandom_range(1, 0));
    end
    key_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    do_reset();
    lut_mode = 1; lut_const = 2;
    key_valid = 1'b1; key_on = 1'b1; key_octave = 3'd0;
    for (int i = 0; i < 8; i++) begin
      key_note = 4'(i);
      checks++;
      if (key_ready !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_ready i=%0d: ready=%b required %0d", i, key_ready, (i % 2) == 0);
      end
      if (key_ready) acc++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (acc != 4 || voice_active !== 4'b1111 || voice_wave !== exp_wave()) begin
      errors++;
      $display("FAIL b2b_accepts: accepts=%0d active=%b required 4/1111", acc, voice_active);
    end
    do_reset();
    send(1'b1, 3, 1);
    n_rst = 1'b0;
    #1;
    checks++;
    if (key_ready !== 1'b1 || voice_active !== '0 || lut_note !== 4'd0) begin
      errors++;
      $display("FAIL midlookup_reset: ready=%b active=%b note=%0d required 1/0000/0",
               key_ready, voice_active, lut_note);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (voice_active !== '0 || voice_active !== exp_active() || key_ready !== 1'b1) begin
        errors++;
        $display("FAIL midlookup_after: active=%b ready=%b required 0000/1", voice_active, key_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_alloc_steal();
    test_retrigger();
    test_illegal();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
